// File: rtl/pu_or1k_pfpu32_f2i_rnd_if.sv
// Operand/result bundle for the PFPU32 float-to-integer converter.
// The unsigned_i request exists only when PU_OR1K_F2I_UNSIGNED_EN is defined.
interface pu_or1k_pfpu32_f2i_rnd_if #(
  parameter int unsigned INT_W = 32
);
  logic             flush_i;
  logic             adv_i;
  logic             start_i;
  logic [1:0]       rmode_i;
  logic             signa_i;
  logic [9:0]       exp10a_i;
  logic [23:0]      fract24a_i;
  logic             snan_i;
  logic             qnan_i;
`ifdef PU_OR1K_F2I_UNSIGNED_EN
  logic             unsigned_i;
`endif
  logic             f2i_rdy_o;
  logic [INT_W-1:0] f2i_int_o;
  logic             f2i_inv_o;
  logic             f2i_ixf_o;
  logic             f2i_snan_o;

`ifdef PU_OR1K_F2I_UNSIGNED_EN
  modport master (
    output flush_i, adv_i, start_i, rmode_i, signa_i, exp10a_i, fract24a_i,
           snan_i, qnan_i, unsigned_i,
    input  f2i_rdy_o, f2i_int_o, f2i_inv_o, f2i_ixf_o, f2i_snan_o
  );
  modport slave (
    input  flush_i, adv_i, start_i, rmode_i, signa_i, exp10a_i, fract24a_i,
           snan_i, qnan_i, unsigned_i,
    output f2i_rdy_o, f2i_int_o, f2i_inv_o, f2i_ixf_o, f2i_snan_o
  );
`else
  modport master (
    output flush_i, adv_i, start_i, rmode_i, signa_i, exp10a_i, fract24a_i,
           snan_i, qnan_i,
    input  f2i_rdy_o, f2i_int_o, f2i_inv_o, f2i_ixf_o, f2i_snan_o
  );
  modport slave (
    input  flush_i, adv_i, start_i, rmode_i, signa_i, exp10a_i, fract24a_i,
           snan_i, qnan_i,
    output f2i_rdy_o, f2i_int_o, f2i_inv_o, f2i_ixf_o, f2i_snan_o
  );
`endif
endinterface

// File: rtl/pu_or1k_pfpu32_f2i_rnd.sv
// Two-stage float-to-integer converter: align (stage 1), round/saturate (stage 2).
// Optional unsigned conversion enabled by defining PU_OR1K_F2I_UNSIGNED_EN.
module pu_or1k_pfpu32_f2i_rnd #(
  parameter int unsigned INT_W = 32
) (
  input logic                     clk,
  input logic                     rst,
  pu_or1k_pfpu32_f2i_rnd_if.slave bus
);
  localparam int unsigned MW = INT_W + 1;
  localparam int unsigned RW = INT_W + 2;
  localparam logic [INT_W:0]   HALF   = {2'b01, {(INT_W-1){1'b0}}};
  localparam logic [INT_W:0]   SMAX   = {2'b00, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] MAXPOS = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] MINNEG = {1'b1, {(INT_W-1){1'b0}}};

  // stage-1 registers
  logic          s1_vld, s1_sign, s1_g, s1_st, s1_povf, s1_qnan, s1_snan, s1_uns;
  logic [1:0]    s1_rm;
  logic [INT_W:0] s1_mag;

  // output registers
  logic             out_rdy, out_inv, out_ixf, out_snan;
  logic [INT_W-1:0] out_int;

  // alignment datapath
  logic [INT_W:0] mag_d;
  logic           g_d, st_d, povf_d;
  logic [6:0]     lsh;
  logic [9:0]     rsh_full;
  logic [4:0]     rsh;
  logic [48:0]    ext;

  // Align the mantissa to the integer point; shifts of 25+ leave only sticky.
  always_comb begin
    mag_d    = '0;
    g_d      = 1'b0;
    st_d     = 1'b0;
    povf_d   = 1'b0;
    lsh      = '0;
    rsh_full = '0;
    rsh      = '0;
    ext      = '0;
    if (bus.exp10a_i > 10'(127 + INT_W)) begin
      povf_d = 1'b1;
    end else if (bus.exp10a_i >= 10'd150) begin
      lsh   = 7'(bus.exp10a_i - 10'd150);
      mag_d = MW'(bus.fract24a_i) << lsh;
    end else begin
      rsh_full = 10'd150 - bus.exp10a_i;
      rsh      = (rsh_full > 10'd25) ? 5'd25 : 5'(rsh_full);
      ext      = {bus.fract24a_i, 25'b0} >> rsh;
      mag_d    = MW'(ext[48:25]);
      g_d      = ext[24];
      st_d     = |ext[23:0];
    end
  end

`ifndef PU_OR1K_F2I_UNSIGNED_EN
  assign s1_uns = 1'b0;
`endif

  // Stage-1 register: valid follows start on advance, flush kills it.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_sign <= 1'b0;
      s1_mag  <= '0;
      s1_g    <= 1'b0;
      s1_st   <= 1'b0;
      s1_povf <= 1'b0;
      s1_qnan <= 1'b0;
      s1_snan <= 1'b0;
      s1_rm   <= '0;
`ifdef PU_OR1K_F2I_UNSIGNED_EN
      s1_uns  <= 1'b0;
`endif
    end else begin
      if (bus.flush_i)    s1_vld <= 1'b0;
      else if (bus.adv_i) s1_vld <= bus.start_i;
      if (bus.adv_i) begin
        s1_sign <= bus.signa_i;
        s1_mag  <= mag_d;
        s1_g    <= g_d;
        s1_st   <= st_d;
        s1_povf <= povf_d;
        s1_qnan <= bus.qnan_i;
        s1_snan <= bus.snan_i;
        s1_rm   <= bus.rmode_i;
`ifdef PU_OR1K_F2I_UNSIGNED_EN
        s1_uns  <= bus.unsigned_i;
`endif
      end
    end
  end

  // rounding/saturation datapath
  logic             inc, nan, ovf, inv, ixf;
  logic [RW-1:0]    rnd;
  logic [INT_W:0]   mag_r;
  logic [INT_W-1:0] res;

  // Round the aligned magnitude, detect overflow, negate or saturate.
  always_comb begin
    inc   = 1'b0;
    ovf   = 1'b0;
    inv   = 1'b0;
    res   = '0;
    case (s1_rm)
      2'd0:    inc = s1_g & (s1_st | s1_mag[0]);
      2'd2:    inc = ~s1_sign & (s1_g | s1_st);
      2'd3:    inc = s1_sign & (s1_g | s1_st);
      default: inc = 1'b0;
    endcase
    rnd   = {1'b0, s1_mag} + RW'(inc);
    mag_r = rnd[INT_W:0];
    nan   = s1_qnan | s1_snan;
    if (s1_uns) begin
      ovf = s1_povf | rnd[RW-1] | mag_r[INT_W];
      if (nan) begin
        res = '1;
        inv = 1'b1;
      end else if (s1_sign) begin
        res = '0;
        inv = ovf | (mag_r != '0);
      end else if (ovf) begin
        res = '1;
        inv = 1'b1;
      end else begin
        res = mag_r[INT_W-1:0];
      end
    end else begin
      ovf = s1_povf | rnd[RW-1] | (s1_sign ? (mag_r > HALF) : (mag_r > SMAX));
      inv = nan | ovf;
      if (nan || (ovf && !s1_sign)) res = MAXPOS;
      else if (ovf)                 res = MINNEG;
      else if (s1_sign)             res = -mag_r[INT_W-1:0];
      else                          res = mag_r[INT_W-1:0];
    end
    ixf = (s1_g | s1_st) & ~inv;
  end

  // Stage-2 register: result and flags; ready follows stage-1 valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_rdy  <= 1'b0;
      out_int  <= '0;
      out_inv  <= 1'b0;
      out_ixf  <= 1'b0;
      out_snan <= 1'b0;
    end else begin
      if (bus.flush_i)    out_rdy <= 1'b0;
      else if (bus.adv_i) out_rdy <= s1_vld;
      if (bus.adv_i) begin
        out_int  <= res;
        out_inv  <= inv;
        out_ixf  <= ixf;
        out_snan <= s1_snan;
      end
    end
  end

  assign bus.f2i_rdy_o  = out_rdy;
  assign bus.f2i_int_o  = out_int;
  assign bus.f2i_inv_o  = out_inv;
  assign bus.f2i_ixf_o  = out_ixf;
  assign bus.f2i_snan_o = out_snan;
endmodule

// File: tb/tb_pu_or1k_pfpu32_f2i_rnd.sv
// Directed bench for the float-to-integer converter, 32- and 64-bit builds.
module tb_pu_or1k_pfpu32_f2i_rnd;
  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pu_or1k_pfpu32_f2i_rnd_if #(.INT_W(32)) a_if ();
  pu_or1k_pfpu32_f2i_rnd_if #(.INT_W(64)) b_if ();

  pu_or1k_pfpu32_f2i_rnd #(.INT_W(32)) u_dut32 (.clk(clk), .rst(rst), .bus(a_if));
  pu_or1k_pfpu32_f2i_rnd #(.INT_W(64)) u_dut64 (.clk(clk), .rst(rst), .bus(b_if));

  // single comparison point
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic drive32(input logic sg, input logic [9:0] ex, input logic [23:0] fr,
                         input logic [1:0] rm, input logic qn, input logic sn);
    a_if.signa_i    = sg;
    a_if.exp10a_i   = ex;
    a_if.fract24a_i = fr;
    a_if.rmode_i    = rm;
    a_if.qnan_i     = qn;
    a_if.snan_i     = sn;
  endtask

  task automatic send32(input string tag, input logic sg, input logic [9:0] ex,
                        input logic [23:0] fr, input logic [1:0] rm, input logic qn,
                        input logic sn, input logic [31:0] e_int, input logic e_inv,
                        input logic e_ixf, input logic e_snan);
    @(negedge clk);
    drive32(sg, ex, fr, rm, qn, sn);
    a_if.start_i = 1'b1;
    @(negedge clk);
    a_if.start_i = 1'b0;
    chk({tag, "/rdy_early"}, 64'(a_if.f2i_rdy_o), 64'd0);
    @(negedge clk);
    chk({tag, "/rdy"}, 64'(a_if.f2i_rdy_o), 64'd1);
    chk({tag, "/int"}, 64'(a_if.f2i_int_o), 64'(e_int));
    chk({tag, "/inv"}, 64'(a_if.f2i_inv_o), 64'(e_inv));
    chk({tag, "/ixf"}, 64'(a_if.f2i_ixf_o), 64'(e_ixf));
    chk({tag, "/snan"}, 64'(a_if.f2i_snan_o), 64'(e_snan));
  endtask

  task automatic send64(input string tag, input logic sg, input logic [9:0] ex,
                        input logic [23:0] fr, input logic [63:0] e_int,
                        input logic e_inv, input logic e_ixf);
    @(negedge clk);
    b_if.signa_i    = sg;
    b_if.exp10a_i   = ex;
    b_if.fract24a_i = fr;
    b_if.rmode_i    = 2'd0;
    b_if.start_i    = 1'b1;
    @(negedge clk);
    b_if.start_i = 1'b0;
    @(negedge clk);
    chk({tag, "/rdy"}, 64'(b_if.f2i_rdy_o), 64'd1);
    chk({tag, "/int"}, b_if.f2i_int_o, e_int);
    chk({tag, "/inv"}, 64'(b_if.f2i_inv_o), 64'(e_inv));
    chk({tag, "/ixf"}, 64'(b_if.f2i_ixf_o), 64'(e_ixf));
  endtask

  initial begin
    rst = 1'b1;
    a_if.flush_i = 1'b0; a_if.adv_i = 1'b0; a_if.start_i = 1'b0;
    b_if.flush_i = 1'b0; b_if.adv_i = 1'b0; b_if.start_i = 1'b0;
    drive32(1'b0, 10'd0, 24'd0, 2'd0, 1'b0, 1'b0);
    b_if.signa_i = 1'b0; b_if.exp10a_i = '0; b_if.fract24a_i = '0;
    b_if.rmode_i = '0; b_if.qnan_i = 1'b0; b_if.snan_i = 1'b0;
`ifdef PU_OR1K_F2I_UNSIGNED_EN
    a_if.unsigned_i = 1'b0;
    b_if.unsigned_i = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset/rdy", 64'(a_if.f2i_rdy_o), 64'd0);
    chk("reset/int", 64'(a_if.f2i_int_o), 64'd0);
    chk("reset/inv", 64'(a_if.f2i_inv_o), 64'd0);
    chk("reset/ixf", 64'(a_if.f2i_ixf_o), 64'd0);
    chk("reset/snan", 64'(a_if.f2i_snan_o), 64'd0);
    chk("reset/int64", b_if.f2i_int_o, 64'd0);
    a_if.adv_i = 1'b1;
    b_if.adv_i = 1'b1;

    // sign, exp, fract, rmode, qnan, snan -> int, inv, ixf, snan
    send32("1.5_rne",   1'b0, 10'd127, 24'hC00000, 2'd0, 1'b0, 1'b0, 32'd2,        1'b0, 1'b1, 1'b0);
    send32("1.5_rtz",   1'b0, 10'd127, 24'hC00000, 2'd1, 1'b0, 1'b0, 32'd1,        1'b0, 1'b1, 1'b0);
    send32("2.5_rne",   1'b0, 10'd128, 24'hA00000, 2'd0, 1'b0, 1'b0, 32'd2,        1'b0, 1'b1, 1'b0);
    send32("m2.5_rdn",  1'b1, 10'd128, 24'hA00000, 2'd3, 1'b0, 1'b0, 32'hFFFFFFFD, 1'b0, 1'b1, 1'b0);
    send32("m2^31",     1'b1, 10'd158, 24'h800000, 2'd0, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b0);
    send32("p2^31",     1'b0, 10'd158, 24'h800000, 2'd0, 1'b0, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0);
    send32("qnan",      1'b0, 10'd255, 24'hC00000, 2'd0, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0);
    send32("snan",      1'b0, 10'd255, 24'hA00000, 2'd0, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b1);
    send32("m0.5_rne",  1'b1, 10'd126, 24'h800000, 2'd0, 1'b0, 1'b0, 32'd0,        1'b0, 1'b1, 1'b0);
    send32("tiny_rup",  1'b0, 10'd1,   24'h000001, 2'd2, 1'b0, 1'b0, 32'd1,        1'b0, 1'b1, 1'b0);
    send32("mtiny_rdn", 1'b1, 10'd1,   24'h000001, 2'd3, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
    send32("mbig",      1'b1, 10'd200, 24'h900000, 2'd0, 1'b0, 1'b0, 32'h80000000, 1'b1, 1'b0, 1'b0);

    send64("w64_2^34",  1'b0, 10'd161, 24'h800000, 64'h0000000400000000, 1'b0, 1'b0);
    send64("w64_m2^63", 1'b1, 10'd190, 24'h800000, 64'h8000000000000000, 1'b0, 1'b0);

    // back-to-back with flush after the second operand
    @(negedge clk);
    drive32(1'b0, 10'd127, 24'hC00000, 2'd1, 1'b0, 1'b0);
    a_if.start_i = 1'b1;
    @(negedge clk);
    drive32(1'b0, 10'd128, 24'hA00000, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("b2b/rdy_a", 64'(a_if.f2i_rdy_o), 64'd1);
    chk("b2b/int_a", 64'(a_if.f2i_int_o), 64'd1);
    drive32(1'b0, 10'd140, 24'h800000, 2'd0, 1'b0, 1'b0);
    a_if.flush_i = 1'b1;
    @(negedge clk);
    a_if.flush_i = 1'b0;
    a_if.start_i = 1'b0;
    chk("flush/rdy0", 64'(a_if.f2i_rdy_o), 64'd0);
    @(negedge clk);
    chk("flush/rdy1", 64'(a_if.f2i_rdy_o), 64'd0);
    @(negedge clk);
    chk("flush/rdy2", 64'(a_if.f2i_rdy_o), 64'd0);

    // advance gap holds both stages
    drive32(1'b0, 10'd128, 24'hA00000, 2'd0, 1'b0, 1'b0);
    a_if.start_i = 1'b1;
    @(negedge clk);
    a_if.adv_i = 1'b0;
    drive32(1'b0, 10'd140, 24'h800000, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("gap/s1_hold", 64'(a_if.f2i_rdy_o), 64'd0);
    end
    a_if.adv_i = 1'b1;
    a_if.start_i = 1'b0;
    @(negedge clk);
    a_if.adv_i = 1'b0;
    chk("gap/rdy", 64'(a_if.f2i_rdy_o), 64'd1);
    chk("gap/int", 64'(a_if.f2i_int_o), 64'd2);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("gap/out_rdy_hold", 64'(a_if.f2i_rdy_o), 64'd1);
      chk("gap/out_int_hold", 64'(a_if.f2i_int_o), 64'd2);
    end
    a_if.adv_i = 1'b1;
    @(negedge clk);
    chk("gap/drain", 64'(a_if.f2i_rdy_o), 64'd0);

    // reset in the middle of a stream
    drive32(1'b0, 10'd255, 24'hC00000, 2'd0, 1'b1, 1'b1);
    a_if.start_i = 1'b1;
    @(negedge clk);
    drive32(1'b0, 10'd127, 24'hC00000, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("mid/rdy", 64'(a_if.f2i_rdy_o), 64'd1);
    chk("mid/inv", 64'(a_if.f2i_inv_o), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst/rdy", 64'(a_if.f2i_rdy_o), 64'd0);
    chk("rst/int", 64'(a_if.f2i_int_o), 64'd0);
    chk("rst/inv", 64'(a_if.f2i_inv_o), 64'd0);
    chk("rst/ixf", 64'(a_if.f2i_ixf_o), 64'd0);
    chk("rst/snan", 64'(a_if.f2i_snan_o), 64'd0);
    rst = 1'b0;
    a_if.start_i = 1'b0;
    @(negedge clk);
    chk("rst/s1_cleared", 64'(a_if.f2i_rdy_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
